// File: rtl/linalg_pkg.sv
// Shared linear-algebra definitions: matrix order, index widths and the
// row/column to flat-index helper used by the streaming blocks.
package linalg_pkg;

  localparam int MAT_N  = 5;
  localparam int IDX_W  = 3;
  localparam int FLAT_W = 5;

  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [FLAT_W-1:0] flat_t;

  typedef enum logic {IDLE, STREAM} state_t;

  function automatic flat_t rc_to_flat(idx_t row, idx_t col);
    return flat_t'(int'(row) * MAT_N + int'(col));
  endfunction

endpackage

// File: rtl/inv_matrix_streamer_if.sv
// Valid/ready beat interface carrying one matrix element plus its row/col
// position and an end-of-matrix flag.
interface inv_matrix_streamer_if #(
  parameter int DATA_W = 32
);
  import linalg_pkg::*;

  logic [DATA_W-1:0] out_data;
  idx_t              out_row;
  idx_t              out_col;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output out_data, out_row, out_col, out_last, out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data, out_row, out_col, out_last, out_valid,
    output out_ready
  );

endinterface

// File: rtl/mat_index_counter.sv
// Row/column walker over an N x N matrix in row- or column-major order.
// The nxt_* outputs expose the upcoming position so the data mux can be registered.
module mat_index_counter
  import linalg_pkg::*;
#(
  parameter int N     = MAT_N,
  parameter int ORDER = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic adv,
  output idx_t row,
  output idx_t col,
  output logic last,
  output idx_t nxt_row,
  output idx_t nxt_col
);

  localparam idx_t TOP = idx_t'(N - 1);

  // Advancing past the final element wraps to the origin so the counter idles clean.
  always_comb begin
    nxt_row = row;
    nxt_col = col;
    if (ORDER == 0) begin
      if (col == TOP) begin
        nxt_col = '0;
        nxt_row = (row == TOP) ? '0 : row + idx_t'(1);
      end else begin
        nxt_col = col + idx_t'(1);
      end
    end else begin
      if (row == TOP) begin
        nxt_row = '0;
        nxt_col = (col == TOP) ? '0 : col + idx_t'(1);
      end else begin
        nxt_row = row + idx_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      row  <= '0;
      col  <= '0;
      last <= 1'b0;
    end else if (adv) begin
      row  <= nxt_row;
      col  <= nxt_col;
      last <= (nxt_row == TOP) && (nxt_col == TOP);
    end
  end

endmodule

// File: rtl/inv_matrix_streamer.sv
// Snapshots the 5x5 inverse from rrefs on start and streams it one element per
// valid/ready beat, tagged with row/col and a last flag.
module inv_matrix_streamer
  import linalg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ORDER  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] inv11, inv12, inv13, inv14, inv15,
  input  logic [DATA_W-1:0] inv21, inv22, inv23, inv24, inv25,
  input  logic [DATA_W-1:0] inv31, inv32, inv33, inv34, inv35,
  input  logic [DATA_W-1:0] inv41, inv42, inv43, inv44, inv45,
  input  logic [DATA_W-1:0] inv51, inv52, inv53, inv54, inv55,
  inv_matrix_streamer_if.master strm,
  output logic              busy,
  output logic              done
);

  localparam int CELLS = MAT_N * MAT_N;

  state_t            state;
  logic [DATA_W-1:0] snap    [CELLS];
  logic [DATA_W-1:0] inv_arr [CELLS];
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  idx_t              row, col, nxt_row, nxt_col;
  logic              last;
  logic              accept, xfer;

  assign inv_arr = '{inv11, inv12, inv13, inv14, inv15,
                     inv21, inv22, inv23, inv24, inv25,
                     inv31, inv32, inv33, inv34, inv35,
                     inv41, inv42, inv43, inv44, inv45,
                     inv51, inv52, inv53, inv54, inv55};

  assign accept = (state == IDLE) && start;
  assign xfer   = (state == STREAM) && valid_q && strm.out_ready;

  mat_index_counter #(
    .N     (MAT_N),
    .ORDER (ORDER)
  ) u_idx (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (accept),
    .adv     (xfer),
    .row     (row),
    .col     (col),
    .last    (last),
    .nxt_row (nxt_row),
    .nxt_col (nxt_col)
  );

  assign strm.out_data  = data_q;
  assign strm.out_row   = row;
  assign strm.out_col   = col;
  assign strm.out_last  = last;
  assign strm.out_valid = valid_q;

  // Element 11 is taken straight from the port on the capture edge; later
  // beats are fetched from the snapshot at the counter's upcoming position.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      data_q  <= '0;
      for (int i = 0; i < CELLS; i++) snap[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= STREAM;
            valid_q <= 1'b1;
            busy    <= 1'b1;
            data_q  <= inv11;
            for (int i = 0; i < CELLS; i++) snap[i] <= inv_arr[i];
          end
        end
        STREAM: begin
          if (xfer) begin
            if (last) begin
              state   <= IDLE;
              valid_q <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              data_q <= snap[rc_to_flat(nxt_row, nxt_col)];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
